regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single register-file write port: round-robin between ALU and load
// results, plus a busy scoreboard that drives issue stalls and source-operand hazards.
module regfile_wb_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        issue_ready,
   input  logic        req0_valid,
   input  logic [4:0]  req0_addr,
   input  logic [31:0] req0_data,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [4:0]  req1_addr,
   input  logic [31:0] req1_data,
   output logic        req1_ready,
   output logic        we3,
   output logic [4:0]  wa3,
   output logic [31:0] wd3,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic        hazard,
   output logic        wb_err
);

   logic [31:0] busy_q, busy_d;
   logic        last_grant_q, last_grant_d;
   logic        we3_q, we3_d;
   logic [4:0]  wa3_q, wa3_d;
   logic [31:0] wd3_q, wd3_d;
   logic        wb_err_q, wb_err_d;

   logic        grant0, grant1, wb_fire, issue_fire;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   // last_grant_q is 1 when req1 won the most recent handshake, so req0 wins the next tie.
   always_comb begin
      grant0     = req0_valid && (!req1_valid || last_grant_q);
      grant1     = req1_valid && !grant0;
      wb_fire    = grant0 || grant1;
      wb_addr    = grant1 ? req1_addr : req0_addr;
      wb_data    = grant1 ? req1_data : req0_data;
      issue_fire = issue_valid && !busy_q[issue_rd];

      last_grant_d = last_grant_q;
      if (wb_fire) begin
         last_grant_d = grant1;
      end

      // Writeback clears first so an issue to the same register in that cycle leaves it busy.
      busy_d = busy_q;
      if (wb_fire && (wb_addr != 5'd0)) begin
         busy_d[wb_addr] = 1'b0;
      end
      if (issue_fire && (issue_rd != 5'd0)) begin
         busy_d[issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;

      we3_d = wb_fire && (wb_addr != 5'd0);
      wa3_d = wa3_q;
      wd3_d = wd3_q;
      if (wb_fire) begin
         wa3_d = wb_addr;
         wd3_d = wb_data;
      end

      wb_err_d = wb_err_q || (we3_d && !busy_q[wb_addr]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q       <= '0;
         last_grant_q <= 1'b1;
         we3_q        <= 1'b0;
         wa3_q        <= '0;
         wd3_q        <= '0;
         wb_err_q     <= 1'b0;
      end else begin
         busy_q       <= busy_d;
         last_grant_q <= last_grant_d;
         we3_q        <= we3_d;
         wa3_q        <= wa3_d;
         wd3_q        <= wd3_d;
         wb_err_q     <= wb_err_d;
      end
   end

   assign issue_ready = !busy_q[issue_rd];
   assign req0_ready  = grant0;
   assign req1_ready  = grant1;
   assign we3         = we3_q;
   assign wa3         = wa3_q;
   assign wd3         = wd3_q;
   assign wb_err      = wb_err_q;
   assign hazard      = ((ra1 != 5'd0) && busy_q[ra1]) || ((ra2 != 5'd0) && busy_q[ra2]);

endmodule
